div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the execute stage, beside the ALU.
//  Takes the same ID/EX operands as the ALU and drives its result into the EX/MEM mux.
//  Holds the pipeline via busy until the result is valid.
//  Radix-2 restoring algorithm on operand magnitudes with sign fix-up; one quotient bit per cycle.
// PARAMETERS
//  XLEN      32   operand/result width
//  CNT_W     6    iteration counter width, >= clog2(XLEN+1)
// PORTS
//  clk        in   1     rising-edge clock
//  reset_n    in   1     asynchronous, active-low reset
//  start      in   1     issue request, sampled only in IDLE
//  kill       in   1     pipeline flush; aborts current operation
//  op         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//  data1      in   XLEN  dividend (rs1)
//  data2      in   XLEN  divisor (rs2)
//  busy       out  1     high while in CALC or DONE; pipeline stall request
//  valid_out  out  1     one-cycle pulse; result valid
//  result     out  XLEN  quotient or remainder per latched op; held until next accepted start
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, busy=0, valid_out=0, result=0, counter=0, all operand regs=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: start=1 & kill=0 -> latch op, |data1|, |data2|, sign flags; counter=XLEN; go CALC.
//    start=1 & kill=1 -> ignored, stay IDLE.
//  CALC: per cycle shift {rem,quo} left 1, trial subtract divisor, keep if non-negative, set quo LSB.
//    Decrement counter; at counter==1 go DONE. Exactly XLEN cycles in CALC.
//  DONE: apply sign fix-up, drive result, valid_out=1 for this cycle only, busy=1; next IDLE.
//  Latency: start sampled at edge T -> valid_out high in the cycle after edge T+XLEN+1.
//  Signs: quotient negated iff dividend/divisor signs differ (signed ops); remainder takes dividend sign.
//  |-2^31| is handled as unsigned 2^31 in XLEN bits (no extra bit needed).
//  Special cases (result always overridden, RISC-V spec):
//    divisor=0: DIV/DIVU quotient = all ones; REM/REMU remainder = data1.
//    DIV with data1=0x80000000, data2=0xFFFFFFFF: quotient=0x80000000; REM remainder=0.
//  start in CALC/DONE: ignored; operands not re-latched.
//  kill in CALC or DONE: next state IDLE, busy=0, valid_out stays 0, result keeps previous value.
//  Reset mid-operation: immediate return to reset values; no valid_out.
// CONFIGURATION
//  DIV_FAST_SPECIAL_EN defined: divisor=0 and signed-overflow cases go IDLE -> DONE directly
//    (valid_out one cycle after start edge, 2-cycle stall); CALC skipped.
//  Not defined: special cases run the full XLEN-cycle CALC; override applied in DONE;
//    identical latency for every operand pair.
//  Result values identical in both builds.
// STRUCTURE
//  Shared header div_defs.vh (`include): state encodings S_IDLE/S_CALC/S_DONE,
//    op codes OP_DIV/OP_DIVU/OP_REM/OP_REMU, XLEN default.
//  Sub-module div_step: combinational single restoring iteration
//    (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once, registered in div_unit.
//  FSM, counter, sign fix-up and special-case override live in div_unit.
// TESTING
//  DIV 20 / -3, start 1 cycle -> valid_out after XLEN+1 cycles, result=0xFFFFFFFA (-6); busy high throughout.
//  REM -20 / 3 -> result=0xFFFFFFFE (-2); REMU 0xFFFFFFFF / 16 -> result=0x0000000F.
//  DIV 0x80000000 / -1 -> 0x80000000; REM same operands -> 0; DIVU 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7;
//    check latency 2 with DIV_FAST_SPECIAL_EN, XLEN+2 without.
//  kill asserted 5 cycles into CALC -> busy=0 next cycle, no valid_out, result unchanged; new start then accepted.
//  start held high during CALC with changed data1/data2 -> result reflects first operands only.
//  reset_n pulsed low mid-CALC (not on edge) -> outputs 0 immediately; 1000 random signed/unsigned pairs vs $signed / % model.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: FSM state encoding, op codes
// (funct3[1:0]) and small op-decode helpers.
package div_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    // Divider control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Operation codes, identical to funct3[1:0] of the M-extension divides
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Signed variants have funct3[0] clear
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Remainder variants have funct3[1] set
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The partial remainder is shifted left with the next dividend bit, the
// divisor is trial-subtracted, and the quotient LSB records whether the
// subtraction was kept.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    // Shifted remainder needs one extra bit: rem < divisor <= 2^XLEN-1
    logic [XLEN:0]   rem_sh_s;
    // One more bit again so the MSB acts as the borrow flag
    logic [XLEN+1:0] diff_s;

    // Trial subtraction and restore/keep selection
    always_comb begin
        rem_sh_s = {rem_in, quo_in[XLEN-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, divisor};
        rem_out  = rem_sh_s[XLEN-1:0];
        quo_out  = {quo_in[XLEN-2:0], 1'b0};
        if (diff_s[XLEN+1] == 1'b0) begin
            rem_out = diff_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = rem_sh_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by sign fix-up and RISC-V special-case override.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow skip the iteration phase and finish one cycle after issue.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] ONE_C     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN_C = {1'b1, {(XLEN-1){1'b0}}};

    // Two's complement negate when requested; |INT_MIN| stays 2^(XLEN-1)
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? (~v + ONE_C) : v;
    endfunction

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [1:0]      op_q, op_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn_s;
    logic            neg1_s;
    logic            neg2_s;
    logic            div0_s;
    logic            ovf_s;
    logic [XLEN-1:0] step_rem_s;
    logic [XLEN-1:0] step_quo_s;
    logic [XLEN-1:0] final_s;

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem_s),
        .quo_out (step_quo_s)
    );

    // Decode issue-time operand properties from the incoming operands
    always_comb begin
        sgn_s  = op_is_signed(op);
        neg1_s = sgn_s & data1[XLEN-1];
        neg2_s = sgn_s & data2[XLEN-1];
        div0_s = (data2 == ZERO_C);
        ovf_s  = sgn_s & (data1 == INT_MIN_C) & (data2 == ONES_C);
    end

    // Sign fix-up and special-case override of the latched operation
    always_comb begin
        final_s = ZERO_C;
        if (op_is_rem(op_q)) begin
            if (div0_q) begin
                final_s = dvd_q;
            end else if (ovf_q) begin
                final_s = ZERO_C;
            end else begin
                final_s = cond_neg(rem_q, rneg_q);
            end
        end else begin
            if (div0_q) begin
                final_s = ONES_C;
            end else if (ovf_q) begin
                final_s = INT_MIN_C;
            end else begin
                final_s = cond_neg(quo_q, qneg_q);
            end
        end
    end

    // FSM next state, iteration datapath and output next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d   = op;
                    dvd_d  = data1;
                    quo_d  = cond_neg(data1, neg1_s);
                    dvs_d  = cond_neg(data2, neg2_s);
                    rem_d  = ZERO_C;
                    qneg_d = neg1_s ^ neg2_s;
                    rneg_d = neg1_s;
                    div0_d = div0_s;
                    ovf_d  = ovf_s;
                    cnt_d  = CNT_W'(XLEN);
`ifdef DIV_FAST_SPECIAL_EN
                    if (div0_s || ovf_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = final_s;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            rem_q    <= ZERO_C;
            quo_q    <= ZERO_C;
            dvs_q    <= ZERO_C;
            dvd_q    <= ZERO_C;
            op_q     <= 2'b00;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= ZERO_C;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random self-checking bench for div_unit (XLEN = 32).
module tb_div_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        valid_out;
    logic [31:0] result;

    int total_cnt;
    int bad_cnt;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .kill      (kill),
        .op        (op),
        .data1     (data1),
        .data2     (data2),
        .busy      (busy),
        .valid_out (valid_out),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference RISC-V divide semantics
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'b00:   model = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b)));
            2'b01:   model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   model = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: model = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation and check latency, busy, result and single-cycle valid
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic hold, input string tag);
        int lat;
        int exp_lat;
        int busy_low;
        exp_lat = 34;
`ifdef DIV_FAST_SPECIAL_EN
        if ((b == 32'd0) || (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
            exp_lat = 2;
`endif
        @(negedge clk);
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            data1 = ~a;
            data2 = b + 32'd5;
        end else begin
            start = 1'b0;
        end
        lat = 1;
        busy_low = 0;
        while (!valid_out && lat < 100) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " valid"}, {31'd0, valid_out}, 32'd1);
        check_val({tag, " result"}, result, exp);
        check_val({tag, " busy_drop"}, 32'(busy_low), 32'd0);
        @(posedge clk); #1;
        check_val({tag, " valid_pulse"}, {31'd0, valid_out}, 32'd0);
        check_val({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        int vcnt;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        total_cnt = 0;
        bad_cnt   = 0;
        reset_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00;
        data1 = 32'd0; data2 = 32'd0;
        #1;
        check_val("reset busy", {31'd0, busy}, 32'd0);
        check_val("reset valid", {31'd0, valid_out}, 32'd0);
        check_val("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors with hand-computed results
        do_op(2'b00, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, "div 20/-3");
        do_op(2'b10, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 1'b0, "rem -20/3");
        do_op(2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 1'b0, "remu ffffffff/16");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "rem ovf");
        do_op(2'b01, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, "divu 7/0");
        do_op(2'b10, 32'd7,         32'd0,         32'h0000_0007, 1'b0, "rem 7/0");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, "div -7/0");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, "rem -7/0");
        do_op(2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, "div -20/-3");
        do_op(2'b10, 32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 1'b0, "rem 20/-3");
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, "divu max/1");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "divu 8000/ffff");
        do_op(2'b01, 32'd100,       32'd7,         32'h0000_000E, 1'b1, "divu hold start");
        do_op(2'b11, 32'd100,       32'd7,         32'h0000_0002, 1'b0, "remu 100/7");

        // start together with kill in IDLE is ignored
        @(negedge clk);
        op = 2'b00; data1 = 32'd50; data2 = 32'd5; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        check_val("idle kill busy", {31'd0, busy}, 32'd0);
        start = 1'b0; kill = 1'b0;

        // kill five cycles into CALC
        @(negedge clk);
        op = 2'b00; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        check_val("kill busy", {31'd0, busy}, 32'd0);
        check_val("kill valid", {31'd0, valid_out}, 32'd0);
        check_val("kill result", result, 32'h0000_0002);
        kill = 1'b0;
        vcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) vcnt++;
        end
        check_val("kill no valid", 32'(vcnt), 32'd0);
        do_op(2'b00, 32'd1000, 32'd3, 32'd333, 1'b0, "after kill");

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        op = 2'b01; data1 = 32'd999; data2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("mid reset busy", {31'd0, busy}, 32'd0);
        check_val("mid reset valid", {31'd0, valid_out}, 32'd0);
        check_val("mid reset result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        vcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_out) vcnt++;
        end
        check_val("post reset no valid", 32'(vcnt), 32'd0);

        // Random operand pairs against the reference model
        for (int i = 0; i < 1000; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = 32'd0 - 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, model(ro, ra, rb), 1'b0, "random");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
